// File: rtl/matrix_lane_alu_pkg.sv
// Shared encodings for matrix_lane_alu: address regions, register map, control bits,
// lane op codes and the sweep FSM states.
package matrix_lane_alu_pkg;

  localparam logic [1:0] RegionRegs = 2'b00;
  localparam logic [1:0] RegionA    = 2'b01;
  localparam logic [1:0] RegionB    = 2'b10;
  localparam logic [1:0] RegionR    = 2'b11;

  localparam int unsigned RegCtrl   = 0;
  localparam int unsigned RegStatus = 1;
  localparam int unsigned RegBase   = 2;
  localparam int unsigned RegCount  = 3;

  localparam int unsigned CtrlStartBit   = 0;
  localparam int unsigned CtrlOpLsb      = 1;
  localparam int unsigned CtrlClrDoneBit = 3;
  localparam int unsigned CtrlIrqEnaBit  = 4;

  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusDoneBit = 1;

  typedef enum logic [1:0] {
    OpAdd    = 2'b00,
    OpSub    = 2'b01,
    OpUmax   = 2'b10,
    OpSatAdd = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StDrain = 2'b10
  } state_e;

endpackage

// File: rtl/matrix_lane_alu_lane_alu.sv
// Combinational lane-wise ALU: applies one op independently to every LANE_WIDTH slice,
// with no carries crossing lane boundaries.
module lane_alu
  import matrix_lane_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE_WIDTH = 8
) (
  input  op_e                   op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  localparam int unsigned Lanes = DATA_WIDTH / LANE_WIDTH;

  for (genvar g = 0; g < Lanes; g++) begin : g_lane
    logic [LANE_WIDTH-1:0] la, lb, ly;
    logic [LANE_WIDTH:0]   sum;

    assign la  = a[g*LANE_WIDTH +: LANE_WIDTH];
    assign lb  = b[g*LANE_WIDTH +: LANE_WIDTH];
    assign sum = {1'b0, la} + {1'b0, lb};

    always_comb begin
      ly = sum[LANE_WIDTH-1:0];
      case (op)
        OpAdd:    ly = sum[LANE_WIDTH-1:0];
        OpSub:    ly = la - lb;
        OpUmax:   ly = (la > lb) ? la : lb;
        // Carry out of the lane means overflow: clamp to all-ones.
        OpSatAdd: ly = sum[LANE_WIDTH] ? {LANE_WIDTH{1'b1}} : sum[LANE_WIDTH-1:0];
        default:  ly = sum[LANE_WIDTH-1:0];
      endcase
    end

    assign y[g*LANE_WIDTH +: LANE_WIDTH] = ly;
  end

endmodule

// File: rtl/matrix_lane_alu.sv
// Avalon-MM lane-wise matrix ALU: R[i] = op(A[i], B[i]) over a wrapping window of words.
// Optional MLA_IRQ_EN adds a registered irq output (DONE & IRQ_ENA) and the IRQ_ENA bit.
module matrix_lane_alu
  import matrix_lane_alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH+1:0]   slave_address,
  input  logic                    slave_read,
  input  logic                    slave_write,
  input  logic [DATA_WIDTH-1:0]   slave_writedata,
  input  logic [DATA_WIDTH/8-1:0] slave_byteenable,
  output logic [DATA_WIDTH-1:0]   slave_readdata
`ifdef MLA_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned Bytes = DATA_WIDTH / 8;

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t mem_a [Depth];
  word_t mem_b [Depth];
  word_t mem_r [Depth];

  // Host-side decode
  logic [1:0]            region;
  logic [ADDR_WIDTH-1:0] idx;
  word_t                 be_mask;
  logic                  sel_ctrl, sel_status, sel_base, sel_count;
  logic                  ctrl_wr, base_wr, count_wr, start_req, clr_req;
  logic                  host_wr_a, host_wr_b;

  // Control/status state
  state_e                state_q;
  logic                  busy_q, done_q, done_d;
  op_e                   op_q, run_op_q;
  logic [ADDR_WIDTH-1:0] base_q, run_base_q;
  logic [ADDR_WIDTH:0]   count_q, run_len_q, step_q;
  logic [ADDR_WIDTH:0]   count_d;
  logic [ADDR_WIDTH-1:0] base_d;

  // Sweep datapath
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr_q;
  logic                  wr_valid_q;
  word_t                 a_q, b_q, alu_y;
  word_t                 rd_word;

`ifdef MLA_IRQ_EN
  logic irq_ena_q, irq_ena_d, irq_q;
`endif

  assign region = slave_address[ADDR_WIDTH+1:ADDR_WIDTH];
  assign idx    = slave_address[ADDR_WIDTH-1:0];

  always_comb begin
    be_mask = '0;
    for (int k = 0; k < Bytes; k++) begin
      be_mask[k*8 +: 8] = {8{slave_byteenable[k]}};
    end
  end

  assign sel_ctrl   = (region == RegionRegs) && (idx == ADDR_WIDTH'(RegCtrl));
  assign sel_status = (region == RegionRegs) && (idx == ADDR_WIDTH'(RegStatus));
  assign sel_base   = (region == RegionRegs) && (idx == ADDR_WIDTH'(RegBase));
  assign sel_count  = (region == RegionRegs) && (idx == ADDR_WIDTH'(RegCount));

  // All CTRL bits live in byte 0.
  assign ctrl_wr   = slave_write && sel_ctrl && slave_byteenable[0];
  assign base_wr   = slave_write && sel_base;
  assign count_wr  = slave_write && sel_count;
  assign start_req = ctrl_wr && slave_writedata[CtrlStartBit] && (state_q == StIdle);
  assign clr_req   = ctrl_wr && slave_writedata[CtrlClrDoneBit];
  assign host_wr_a = slave_write && (region == RegionA) && !busy_q;
  assign host_wr_b = slave_write && (region == RegionB) && !busy_q;

  assign base_d  = ADDR_WIDTH'((DATA_WIDTH'(base_q) & ~be_mask)
                               | (slave_writedata & be_mask));
  assign count_d = (ADDR_WIDTH+1)'((DATA_WIDTH'(count_q) & ~be_mask)
                                   | (slave_writedata & be_mask));

  // Completion wins over a clear landing in the DRAIN cycle; START always clears.
  always_comb begin
    done_d = done_q;
    if (clr_req || start_req) done_d = 1'b0;
    if (state_q == StDrain)   done_d = 1'b1;
  end

`ifdef MLA_IRQ_EN
  assign irq_ena_d = ctrl_wr ? slave_writedata[CtrlIrqEnaBit] : irq_ena_q;
  assign irq       = irq_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      op_q       <= OpAdd;
      run_op_q   <= OpAdd;
      base_q     <= '0;
      run_base_q <= '0;
      count_q    <= '0;
      run_len_q  <= '0;
      step_q     <= '0;
      wr_valid_q <= 1'b0;
`ifdef MLA_IRQ_EN
      irq_ena_q  <= 1'b0;
      irq_q      <= 1'b0;
`endif
    end else begin
      if (ctrl_wr)  op_q    <= op_e'(slave_writedata[CtrlOpLsb +: 2]);
      if (base_wr)  base_q  <= base_d;
      if (count_wr) count_q <= count_d;
      done_q     <= done_d;
      wr_valid_q <= (state_q == StRun);
`ifdef MLA_IRQ_EN
      irq_ena_q  <= irq_ena_d;
      irq_q      <= done_d & irq_ena_d;
`endif
      case (state_q)
        StIdle: begin
          if (start_req) begin
            state_q    <= StRun;
            busy_q     <= 1'b1;
            // The op written alongside START is the one this run uses.
            run_op_q   <= op_e'(slave_writedata[CtrlOpLsb +: 2]);
            run_base_q <= base_q;
            run_len_q  <= (count_q == '0) ? (ADDR_WIDTH+1)'(Depth) : count_q;
            step_q     <= '0;
          end
        end
        StRun: begin
          step_q <= step_q + 1'b1;
          if (step_q == run_len_q - 1'b1) state_q <= StDrain;
        end
        StDrain: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Window index wraps naturally in ADDR_WIDTH bits.
  assign rd_addr = run_base_q + step_q[ADDR_WIDTH-1:0];

  lane_alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .LANE_WIDTH(LANE_WIDTH)
  ) u_lane_alu (
    .op(run_op_q),
    .a (a_q),
    .b (b_q),
    .y (alu_y)
  );

  always_ff @(posedge clk) begin
    for (int k = 0; k < Bytes; k++) begin
      if (host_wr_a && slave_byteenable[k]) mem_a[idx][k*8 +: 8] <= slave_writedata[k*8 +: 8];
      if (host_wr_b && slave_byteenable[k]) mem_b[idx][k*8 +: 8] <= slave_writedata[k*8 +: 8];
    end
    if (wr_valid_q) mem_r[wr_addr_q] <= alu_y;
    a_q       <= mem_a[rd_addr];
    b_q       <= mem_b[rd_addr];
    wr_addr_q <= rd_addr;
  end

  always_comb begin
    rd_word = '0;
    case (region)
      RegionRegs: begin
        if (sel_ctrl) begin
          rd_word[CtrlOpLsb +: 2] = op_q;
`ifdef MLA_IRQ_EN
          rd_word[CtrlIrqEnaBit] = irq_ena_q;
`endif
        end else if (sel_status) begin
          rd_word[StatusBusyBit] = busy_q;
          rd_word[StatusDoneBit] = done_q;
        end else if (sel_base) begin
          rd_word[ADDR_WIDTH-1:0] = base_q;
        end else if (sel_count) begin
          rd_word[ADDR_WIDTH:0] = count_q;
        end
      end
      RegionA: if (!busy_q) rd_word = mem_a[idx];
      RegionB: if (!busy_q) rd_word = mem_b[idx];
      RegionR: if (!busy_q) rd_word = mem_r[idx];
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slave_readdata <= '0;
    end else if (slave_read) begin
      slave_readdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_matrix_lane_alu.sv
// Directed scoreboard bench for matrix_lane_alu: reads push expected words, a monitor
// pops and compares them one cycle after each read strobe.
module tb_matrix_lane_alu;
  import matrix_lane_alu_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 8;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW+1:0] slave_address;
  logic          slave_read, slave_write;
  logic [DW-1:0] slave_writedata;
  logic [3:0]    slave_byteenable;
  logic [DW-1:0] slave_readdata;
`ifdef MLA_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  matrix_lane_alu #(
    .DATA_WIDTH(DW),
    .LANE_WIDTH(LW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .slave_address   (slave_address),
    .slave_read      (slave_read),
    .slave_write     (slave_write),
    .slave_writedata (slave_writedata),
    .slave_byteenable(slave_byteenable),
    .slave_readdata  (slave_readdata)
`ifdef MLA_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  logic [DW-1:0] exp_q[$];
  string         name_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          rd_fire = 1'b0;

  task automatic check(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, got, exp);
    end
  endtask

  always @(posedge clk) rd_fire <= slave_read && !reset;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got %08h expected no read", slave_readdata);
      end else begin
        logic [DW-1:0] e;
        string         nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, slave_readdata, e);
      end
    end
  end

  task automatic drive(input bit wr, input bit rd, input logic [1:0] rg, input int idx,
                       input logic [DW-1:0] d);
    @(negedge clk);
    slave_write      = wr;
    slave_read       = rd;
    slave_address    = {rg, 8'(idx)};
    slave_writedata  = d;
    slave_byteenable = 4'hF;
  endtask

  task automatic wr(input logic [1:0] rg, input int idx, input logic [DW-1:0] d);
    drive(1'b1, 1'b0, rg, idx, d);
  endtask

  task automatic rd(input logic [1:0] rg, input int idx, input logic [DW-1:0] e,
                    input string nm);
    drive(1'b0, 1'b1, rg, idx, '0);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, RegionRegs, 0, '0);
  endtask

  // START in cycle 0; STATUS read in cycle n+1 must be BUSY and in cycle n+2 DONE.
  task automatic run(input logic [DW-1:0] ctrl, input int n, input string nm);
    wr(RegionRegs, RegCtrl, ctrl);
    repeat (n) idle();
    rd(RegionRegs, RegStatus, 32'h1, {nm, "_busy_last"});
    rd(RegionRegs, RegStatus, 32'h2, {nm, "_done_n2"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int fix [7] = '{253, 254, 255, 0, 1, 2, 5};
    reset = 1'b1;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0;
    slave_writedata = '0; slave_byteenable = '0;
    repeat (2) @(negedge clk);
    check("reset_readdata", slave_readdata, 32'h0);
    reset = 1'b0;

    rd(RegionRegs, RegCtrl,   32'h0, "rst_ctrl");
    rd(RegionRegs, RegStatus, 32'h0, "rst_status");
    rd(RegionRegs, RegBase,   32'h0, "rst_base");
    rd(RegionRegs, RegCount,  32'h0, "rst_count");
    wr(RegionRegs, 4, 32'hFFFF_FFFF);
    rd(RegionRegs, 4, 32'h0, "unused_offset");

    for (int i = 0; i < DEPTH; i++) begin
      wr(RegionA, i, 32'h0102_0304);
      wr(RegionB, i, 32'h10FF_2030);
    end
    rd(RegionA, 7, 32'h0102_0304, "idle_read_a");

    // Full-depth add
    run(32'h1, DEPTH, "add_full");
    for (int i = 0; i < DEPTH; i++) rd(RegionR, i, 32'h1101_2334, $sformatf("add_r%0d", i));

    // Sub and umax on a single word
    wr(RegionA, 5, 32'h05FF_0010);
    wr(RegionB, 5, 32'h0A01_FF08);
    wr(RegionRegs, RegBase, 32'd5);
    wr(RegionRegs, RegCount, 32'd1);
    run(32'h3, 1, "sub");
    rd(RegionR, 5, 32'hFBFE_0108, "sub_r5");
    rd(RegionR, 4, 32'h1101_2334, "sub_r4_kept");
    run(32'h5, 1, "umax");
    rd(RegionR, 5, 32'h0AFF_FF10, "umax_r5");

    // Saturating add
    wr(RegionA, 0, 32'hF080_7F01);
    wr(RegionB, 0, 32'h2080_7F01);
    wr(RegionRegs, RegBase, 32'd0);
    run(32'h7, 1, "sat");
    rd(RegionR, 0, 32'hFFFF_FE02, "sat_r0");
    rd(RegionR, 1, 32'h1101_2334, "sat_r1_kept");
    rd(RegionRegs, RegCtrl, 32'h6, "ctrl_op_readback");

    // Wrap window with host traffic during the run
    for (int i = 253; i < 259; i++) begin
      wr(RegionA, i % DEPTH, 32'h0000_0001);
      wr(RegionB, i % DEPTH, 32'h10FF_2030);
    end
    wr(RegionRegs, RegBase, 32'd254);
    wr(RegionRegs, RegCount, 32'd4);
    wr(RegionRegs, RegCtrl, 32'h1);
    rd(RegionRegs, RegStatus, 32'h1, "wrap_status_busy");
    wr(RegionA, 254, 32'hDEAD_BEEF);
    wr(RegionRegs, RegCtrl, 32'h1);
    rd(RegionA, 1, 32'h0, "busy_read_zero");
    rd(RegionRegs, RegStatus, 32'h1, "wrap_busy_last");
    rd(RegionRegs, RegStatus, 32'h2, "wrap_done_n2");
    rd(RegionR, 253, 32'h1101_2334, "wrap_r253_kept");
    rd(RegionR, 254, 32'h10FF_2031, "wrap_r254");
    rd(RegionR, 255, 32'h10FF_2031, "wrap_r255");
    rd(RegionR, 0,   32'h10FF_2031, "wrap_r0");
    rd(RegionR, 1,   32'h10FF_2031, "wrap_r1");
    rd(RegionR, 2,   32'h1101_2334, "wrap_r2_kept");
    rd(RegionA, 254, 32'h0000_0001, "busy_write_dropped");

    // CLR_DONE, then START together with CLR_DONE
    wr(RegionRegs, RegCtrl, 32'h8);
    rd(RegionRegs, RegStatus, 32'h0, "clr_done");
    run(32'h9, 4, "start_clr");

    // Reset partway through a full run
    wr(RegionRegs, RegBase, 32'd0);
    wr(RegionRegs, RegCount, 32'd0);
    wr(RegionRegs, RegCtrl, 32'h1);
    repeat (9) idle();
    @(negedge clk);
    slave_write = 1'b0;
    slave_read  = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(RegionRegs, RegStatus, 32'h0, "midrun_reset_status");
    rd(RegionRegs, RegCount,  32'h0, "midrun_reset_count");

    foreach (fix[k]) begin
      wr(RegionA, fix[k], 32'h0102_0304);
      wr(RegionB, fix[k], 32'h10FF_2030);
    end
    run(32'h3, DEPTH, "sub_full");
    for (int i = 0; i < DEPTH; i++) rd(RegionR, i, 32'hF103_E3D4, $sformatf("sub_r%0d", i));

`ifdef MLA_IRQ_EN
    wr(RegionRegs, RegCount, 32'd1);
    run(32'h11, 1, "irq_run");
    idle();
    check("irq_set", {31'b0, irq}, 32'h1);
    rd(RegionRegs, RegCtrl, 32'h10, "irq_ena_readback");
    wr(RegionRegs, RegCtrl, 32'h18);
    idle();
    check("irq_clear", {31'b0, irq}, 32'h0);
`else
    wr(RegionRegs, RegCtrl, 32'h10);
    rd(RegionRegs, RegCtrl, 32'h0, "irq_ena_absent");
`endif

    repeat (3) idle();
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL pending_reads: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/matrix_lane_alu.md
Name: matrix_lane_alu

Overview:
- Parametrised successor to the fixed 256x32 byte-lane matrix adder, sitting as an Avalon-MM slave on the HPS lightweight bridge.
- Holds operand memories A and B and a result memory R, each DEPTH words of DATA_WIDTH bits.
- On start, a single FSM sweeps a programmable window of words and writes a lane-wise op(A, B) result into R at one word per cycle.
- Selectable ops: add, sub, unsigned max, saturating add. Busy and done are visible in a status register.

Parameters:
- DATA_WIDTH, 32: word width; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 8: independent lane width; lanes = DATA_WIDTH/LANE_WIDTH.
- ADDR_WIDTH, 8: word address width; DEPTH = 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- slave_address  in  ADDR_WIDTH+2  bits [top:top-1] select the region: 00 regs, 01 A, 10 B, 11 R. Low ADDR_WIDTH bits are the word index.
- slave_read  in  1  Avalon read strobe; fixed read latency 1.
- slave_write  in  1  Avalon write strobe.
- slave_writedata  in  DATA_WIDTH  write data.
- slave_byteenable  in  DATA_WIDTH/8  per-byte write mask, applied to A/B and register writes.
- slave_readdata  out  DATA_WIDTH  registered read data, valid the cycle after slave_read.
- irq  out  1  present only with MLA_IRQ_EN.

Behaviour:
- Register map (regs region, word offsets):
  - 0 CTRL: bit0 START, write-1 pulse, reads 0; bits[2:1] OP (00 add, 01 sub, 10 umax, 11 sat-add); bit3 CLR_DONE, write-1 pulse; bit4 IRQ_ENA.
  - 1 STATUS (read-only): bit0 BUSY, bit1 DONE.
  - 2 BASE: first word index, ADDR_WIDTH bits.
  - 3 COUNT: number of words, ADDR_WIDTH+1 bits; 0 means DEPTH.
  - Other offsets read 0 and ignore writes.
- Reset values: slave_readdata=0, irq=0, OP=0, IRQ_ENA=0, BASE=0, COUNT=0, BUSY=0, DONE=0, FSM=IDLE. Memory contents are not reset.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on a START write. In the same cycle: latch OP, BASE and COUNT into working copies, clear DONE, set BUSY.
  - RUN: issue read address BASE+i (mod DEPTH) each cycle, i = 0..N-1. The RAM returns data one cycle later; R[BASE+i] is written with lane_op(A, B) the following cycle.
  - RUN -> DRAIN after issuing index N-1.
  - DRAIN: the last write completes. -> IDLE with BUSY=0, DONE=1.
- Latency: START accepted at cycle 0 -> DONE visible in STATUS at cycle N+2.
- Lane arithmetic, per lane, independent, no carries across lanes:
  - add: mod 2**LANE_WIDTH.
  - sub: A-B mod 2**LANE_WIDTH.
  - umax: unsigned maximum.
  - sat-add: clamps to all-ones.
- Address wrap: window indices wrap modulo DEPTH. BASE=DEPTH-2 with COUNT=4 processes DEPTH-2, DEPTH-1, 0, 1.
- Host access while BUSY:
  - A/B writes are dropped.
  - A/B/R reads return 0.
  - Reg reads and writes proceed, except that a START write is ignored.
  - BASE, COUNT and OP writes affect only the next run.
- Host access in IDLE:
  - Writes to the R region are always ignored.
  - A/B/R reads return the RAM word one cycle later.
- Simultaneous events: START and CLR_DONE written together in IDLE starts the run; DONE stays 0.
- CLR_DONE with DONE=0 has no effect.
- Reset asserted mid-run: returns to IDLE immediately with BUSY=0 and DONE=0. Partially written R contents are retained but undefined.

Optional Feature:
- Macro: MLA_IRQ_EN.
- Defined: adds the irq port, driven as a registered DONE & IRQ_ENA. It deasserts the cycle after CLR_DONE or a new START.
- Undefined: no irq port, and the IRQ_ENA bit reads 0.

Decomposition:
- Package matrix_lane_alu_pkg holds:
  - region codes;
  - register offsets;
  - CTRL/STATUS bit positions;
  - op codes;
  - FSM state encoding.
- One sub-module, lane_alu: combinational, parametrised on DATA_WIDTH/LANE_WIDTH, op input, applies the op across all lanes.
- Memories are inferred simple dual-port arrays inside the top module.

Test Plan:
- Add, full depth: A[i]=0x01020304, B[i]=0x10FF2030 for all i, OP=add, COUNT=0, START -> every R[i]=0x11012334; DONE at cycle DEPTH+2.
- Sub/umax: A[5]=0x05FF0010, B[5]=0x0A01FF08, BASE=5, COUNT=1:
  - sub -> R[5]=0xFBFE0108;
  - umax -> R[5]=0x0AFFFF10.
- Saturating add: A[0]=0xF0807F01, B[0]=0x20807F01, sat-add -> R[0]=0xFFFFFE02. Other R words are unchanged.
- Wrap: DEPTH=256, BASE=254, COUNT=4 -> only R[254], R[255], R[0], R[1] are written. During the run, STATUS=0x1, an A write is dropped and a second START is ignored.
- Reset mid-run: assert reset at cycle 10 of a 256-word run -> STATUS=0x0. A following full run completes correctly.
- MLA_IRQ_EN: IRQ_ENA=1 and a run completes -> irq=1. Write CLR_DONE -> irq=0 the next cycle.
